ram_line_stream_reader: RTL

// - Read-side client for the 1RW/1W byte-mask line RAM.
// - Accepts a request (start line, byte length) and issues sequential line reads on the RAM's

---
 rtl/ram_reader_pkg.sv | 20 ++
 rtl/ram_reader_out_buf.sv | 43 ++++
 rtl/ram_line_stream_reader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_reader_pkg.sv
// Shared types for the line RAM stream reader: FSM states, buffered output line and a sizing helper.
package ram_reader_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} reader_state_e;

  localparam int line_width_gp = 512;
  localparam int pad_width_gp  = 6;

  // Default-geometry line; the top rebuilds this shape for its own width_p.
  typedef struct packed {
    logic [line_width_gp-1:0] data;
    logic                     last;
    logic [pad_width_gp-1:0]  padbytes;
  } out_line_s;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ram_reader_out_buf.sv
// Two-entry valid/ready FIFO holding lines returned from the RAM, with occupancy for credit accounting.
module ram_reader_out_buf
  import ram_reader_pkg::*;
#(
  parameter type elem_t = out_line_s
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       push_i,
  input  elem_t      push_data_i,
  input  logic       pop_rdy_i,
  output logic       val_o,
  output elem_t      data_o,
  output logic [1:0] occ_o
);

  elem_t      mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] occ;
  logic       pop;

  assign val_o  = (occ != 2'd0);
  assign pop    = val_o & pop_rdy_i;
  assign data_o = mem[rd_ptr];
  assign occ_o  = occ;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push_i) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push_i) - 2'(pop);
    end
  end

endmodule

// File: rtl/ram_line_stream_reader.sv
// Streams a byte-length request out of the line RAM: issues sequential reads, absorbs the
// one-cycle read latency and presents lines on a valid/ready port with last/pad marking.
module ram_line_stream_reader
  import ram_reader_pkg::*;
#(
  parameter  int width_p       = 512,
  parameter  int els_p         = 256,
  parameter  int len_width_p   = 16,
  localparam int addr_width_lp = safe_clog2(els_p),
  localparam int bytes_lp      = width_p / 8,
  localparam int pad_width_lp  = safe_clog2(bytes_lp)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_val_i,
  input  logic [addr_width_lp-1:0] req_line_i,
  input  logic [len_width_p-1:0]   req_len_i,
  output logic                     req_rdy_o,
  output logic                     rd_v_o,
  output logic [addr_width_lp-1:0] rd_addr_o,
  input  logic                     rd_gnt_i,
  input  logic [width_p-1:0]       rd_data_i,
  output logic                     data_val_o,
  output logic [width_p-1:0]       data_o,
  output logic                     data_last_o,
  output logic [pad_width_lp-1:0]  data_padbytes_o,
  input  logic                     data_rdy_i
);

  localparam int lw1_lp = len_width_p + 1;

  typedef struct packed {
    logic [width_p-1:0]      data;
    logic                    last;
    logic [pad_width_lp-1:0] padbytes;
  } line_t;

  reader_state_e            state;
  logic [addr_width_lp-1:0] addr;
  logic [len_width_p-1:0]   lines_left;
  logic [pad_width_lp-1:0]  pad;
  logic                     inflight, inflight_last;

  logic [lw1_lp-1:0]        len_ext, lines_calc, rem_calc;
  logic [pad_width_lp-1:0]  pad_calc;
  logic [1:0]               occ;
  logic [2:0]               committed;
  logic                     pop, credit_ok, granted, last_grant;
  line_t                    push_line, out_line;

  // Line count rounds up; pad is whatever the final line carries beyond req_len_i.
  always_comb begin
    len_ext    = {1'b0, req_len_i};
    lines_calc = (len_ext + lw1_lp'(bytes_lp - 1)) / lw1_lp'(bytes_lp);
    rem_calc   = len_ext % lw1_lp'(bytes_lp);
    pad_calc   = (rem_calc == '0) ? '0 : pad_width_lp'(lw1_lp'(bytes_lp) - rem_calc);
  end

  // Buffer slots already claimed by stored lines plus the read whose data lands next cycle.
  assign pop        = data_val_o & data_rdy_i;
  assign committed  = 3'(occ) + 3'(inflight);
  assign credit_ok  = (committed < 3'd2) || ((committed == 3'd2) && pop);
  assign rd_v_o     = (state == ISSUE) && credit_ok;
  assign rd_addr_o  = addr;
  assign req_rdy_o  = (state == IDLE);
  assign granted    = rd_v_o & rd_gnt_i;
  assign last_grant = granted && (lines_left == len_width_p'(1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      addr          <= '0;
      lines_left    <= '0;
      pad           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= granted;
      inflight_last <= last_grant;
      case (state)
        IDLE: if (req_val_i && (req_len_i != '0)) begin
          addr       <= req_line_i;
          lines_left <= lines_calc[len_width_p-1:0];
          pad        <= pad_calc;
          state      <= ISSUE;
        end
        ISSUE: if (granted) begin
          addr       <= (addr == addr_width_lp'(els_p - 1)) ? '0 : addr + 1'b1;
          lines_left <= lines_left - 1'b1;
          if (last_grant) state <= DRAIN;
        end
        DRAIN: if (pop && data_last_o) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    push_line          = '0;
    push_line.data     = rd_data_i;
    push_line.last     = inflight_last;
    push_line.padbytes = inflight_last ? pad : '0;
  end

  ram_reader_out_buf #(.elem_t(line_t)) u_out_buf (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .push_i     (inflight),
    .push_data_i(push_line),
    .pop_rdy_i  (data_rdy_i),
    .val_o      (data_val_o),
    .data_o     (out_line),
    .occ_o      (occ)
  );

  assign data_o          = out_line.data;
  assign data_last_o     = out_line.last;
  assign data_padbytes_o = out_line.padbytes;

endmodule
